// File: rtl/demux_gate_pkg.sv
// Shared opcode encodings and width constants for demux_gate_router and gate_eval.
package demux_gate_pkg;

    localparam int OP_W   = 3;
    localparam int STAT_W = 8;

    localparam logic [OP_W-1:0] OP_NAND = 3'd0;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/demux_gate_router_gate_eval.sv
// gate_eval: combinational bitwise logic unit shared ahead of the channel demux.
module gate_eval
    import demux_gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/demux_gate_router.sv
// demux_gate_router: evaluates a bitwise logic op and routes the result into one of NUM_CH
// single-entry output channels. Define DEMUX_STAT_EN to add per-channel consumed-result counters.
module demux_gate_router
    import demux_gate_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [OP_W-1:0]            in_op,
    input  logic [SEL_W-1:0]           in_sel,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*WIDTH-1:0]    out_data,
`ifdef DEMUX_STAT_EN
    output logic [NUM_CH*STAT_W-1:0]   stat_cnt,
`endif
    output logic                       err_sel
);

    localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

    logic [WIDTH-1:0]  w_result;
    logic              w_selBad;
    logic              w_accept;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_free;
    logic              r_valid [NUM_CH];
    logic [WIDTH-1:0]  r_data  [NUM_CH];
    logic              r_errSel;

    gate_eval #(.WIDTH(WIDTH)) u_gate (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .y  (w_result)
    );

    assign w_selBad = (32'(in_sel) >= NUM_CH_U);

    // A channel can take a new request when it is empty or is being drained this same cycle.
    always_comb begin
        w_hit  = '0;
        w_free = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k]  = (32'(in_sel) == 32'(k));
            w_free[k] = !r_valid[k] || out_ready[k];
        end
    end

    assign in_ready = w_selBad || |(w_hit & w_free);
    assign w_accept = in_valid && in_ready && !w_selBad;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end else if (w_accept && w_hit[k]) begin
                r_valid[k] <= 1'b1;
                r_data[k]  <= w_result;
            end else if (out_ready[k]) begin
                r_valid[k] <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_valid[k]               = r_valid[k];
            out_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errSel <= 1'b0;
        end else begin
            r_errSel <= in_valid && w_selBad;
        end
    end

    assign err_sel = r_errSel;

`ifdef DEMUX_STAT_EN
    logic [STAT_W-1:0] r_cnt [NUM_CH];

    // Counters stick at all-ones rather than wrapping.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (r_valid[k] && out_ready[k] && (r_cnt[k] != '1)) begin
                r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            stat_cnt[k*STAT_W +: STAT_W] = r_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux_gate_router.sv
// Randomized, model-checked bench for demux_gate_router (4-channel main instance plus a 3-channel instance).
module tb_demux_gate_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [2:0]  in_op;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic        err_sel;

    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [11:0] out_data3;
    logic        err_sel3;

`ifdef DEMUX_STAT_EN
    logic [31:0] stat_cnt;
    logic [23:0] stat_cnt3;
`endif

    int checks   = 0;
    int failures = 0;

    logic       mValid [4];
    logic [3:0] mData  [4];
    logic [7:0] mCnt   [4];
    logic       expReady;
    logic       obsReady;

    always #5 clk = ~clk;

    demux_gate_router #(.WIDTH(4), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_STAT_EN
        .stat_cnt  (stat_cnt),
`endif
        .err_sel   (err_sel)
    );

    demux_gate_router #(.WIDTH(4), .NUM_CH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_sel    (in_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
`ifdef DEMUX_STAT_EN
        .stat_cnt  (stat_cnt3),
`endif
        .err_sel   (err_sel3)
    );

    function automatic logic [3:0] ref_gate(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return ~(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = mValid[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = 4'h0;
            mCnt[k]   = 8'd0;
        end
    endtask

    // One clock of main-instance traffic; model advances from its pre-edge state.
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [1:0] sel, input logic [3:0] rdy);
        logic accepted;
        logic consumed;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_sel    = sel;
        out_ready = rdy;
        #1;
        expReady = !mValid[sel] || rdy[sel];
        obsReady = in_ready;
        accepted = v && expReady;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            consumed = mValid[k] && rdy[k];
            if (consumed && mCnt[k] != 8'd255) mCnt[k] = mCnt[k] + 8'd1;
            if (accepted && sel == 2'(k)) begin
                mValid[k] = 1'b1;
                mData[k]  = ref_gate(a, b, op);
            end else if (consumed) begin
                mValid[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_sel = 0; out_ready = 0;
        in_valid3 = 0; in_sel3 = 0; out_ready3 = 0;
        model_reset();
        #12;
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 16'h0 || err_sel !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: valid=%b data=%h err=%b required valid=0000 data=0000 err=0", out_valid, out_data, err_sel);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b required 1", in_ready);
        end
        drive(1'b1, 4'h3, 4'h5, 3'd2, 2'd2, 4'b0000);
        checks++;
        if (out_valid !== 4'b0100 || out_data[11:8] !== 4'h1) begin
            failures++;
            $display("[TB] FAIL reset_fill_ch2: valid=%b ch2=%h required valid=0100 ch2=1", out_valid, out_data[11:8]);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_async: valid=%b data=%h required valid=0000 data=0000", out_valid, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b required ready=1 valid=0000", in_ready, out_valid);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] table_q [8];
        table_q = '{4'b1110, 4'b1000, 4'b0001, 4'b0111, 4'b0110, 4'b1001, 4'b1100, 4'b0011};
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 4'b0011, 4'b0101, 3'(op), 2'd1, 4'b0010);
            checks++;
            if (obsReady !== 1'b1 || out_valid[1] !== 1'b1 || out_data[7:4] !== table_q[op]) begin
                failures++;
                $display("[TB] FAIL truth_op%0d: ready=%b valid1=%b ch1=%b required ready=1 valid1=1 ch1=%b", op, obsReady, out_valid[1], out_data[7:4], table_q[op]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 2'd0, 4'hF);
        drive(1'b1, 4'hF, 4'hF, 3'd0, 2'd0, 4'b0000);
        checks++;
        if (obsReady !== 1'b1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h0) begin
            failures++;
            $display("[TB] FAIL bp_first: ready=%b valid0=%b ch0=%h required ready=1 valid0=1 ch0=0", obsReady, out_valid[0], out_data[3:0]);
        end
        drive(1'b1, 4'hF, 4'hF, 3'd2, 2'd0, 4'b0000);
        checks++;
        if (obsReady !== 1'b0 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h0) begin
            failures++;
            $display("[TB] FAIL bp_stall: ready=%b valid0=%b ch0=%h required ready=0 valid0=1 ch0=0", obsReady, out_valid[0], out_data[3:0]);
        end
        drive(1'b1, 4'hF, 4'hF, 3'd2, 2'd0, 4'b0001);
        checks++;
        if (obsReady !== 1'b1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'hF) begin
            failures++;
            $display("[TB] FAIL bp_replace: ready=%b valid0=%b ch0=%h required ready=1 valid0=1 ch0=f", obsReady, out_valid[0], out_data[3:0]);
        end
    endtask

    task automatic test_independence();
        drive(1'b1, 4'h0, 4'h0, 3'd1, 2'd3, 4'b0000);
        checks++;
        if (obsReady !== 1'b1 || out_valid !== 4'b1001 || out_data[15:12] !== 4'hF || out_data[3:0] !== 4'hF) begin
            failures++;
            $display("[TB] FAIL independence: ready=%b valid=%b data=%h required ready=1 valid=1001 ch3=f ch0=f", obsReady, out_valid, out_data);
        end
    endtask

    task automatic test_invalid_sel();
        in_valid = 1'b0;
        in_a = 4'h5; in_op = 3'd7;
        in_valid3 = 1'b1; in_sel3 = 2'd0; out_ready3 = 3'b000;
        @(posedge clk); #1;
        checks++;
        if (out_valid3 !== 3'b001 || out_data3[3:0] !== 4'h5 || err_sel3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL inv_setup: valid=%b ch0=%h err=%b required valid=001 ch0=5 err=0", out_valid3, out_data3[3:0], err_sel3);
        end
        in_sel3 = 2'd3; in_a = 4'hA;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL inv_ready: got %b required 1", in_ready3);
        end
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        checks++;
        if (err_sel3 !== 1'b1 || out_valid3 !== 3'b001 || out_data3[3:0] !== 4'h5) begin
            failures++;
            $display("[TB] FAIL inv_pulse: err=%b valid=%b ch0=%h required err=1 valid=001 ch0=5", err_sel3, out_valid3, out_data3[3:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (err_sel3 !== 1'b0 || out_valid3 !== 3'b001) begin
            failures++;
            $display("[TB] FAIL inv_clear: err=%b valid=%b required err=0 valid=001", err_sel3, out_valid3);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom));
            checks++;
            if (obsReady !== expReady || out_valid !== exp_valid() || err_sel !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand_ctrl[%0d]: ready=%b valid=%b err=%b required ready=%b valid=%b err=0", n, obsReady, out_valid, err_sel, expReady, exp_valid());
            end
            for (int k = 0; k < 4; k++) begin
                if (mValid[k]) begin
                    checks++;
                    if (out_data[k*4 +: 4] !== mData[k]) begin
                        failures++;
                        $display("[TB] FAIL rand_data[%0d] ch%0d: got %h required %h", n, k, out_data[k*4 +: 4], mData[k]);
                    end
                end
`ifdef DEMUX_STAT_EN
                checks++;
                if (stat_cnt[k*8 +: 8] !== mCnt[k]) begin
                    failures++;
                    $display("[TB] FAIL rand_stat[%0d] ch%0d: got %0d required %0d", n, k, stat_cnt[k*8 +: 8], mCnt[k]);
                end
`endif
            end
        end
    endtask

`ifdef DEMUX_STAT_EN
    task automatic test_stat_saturate();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 2'd2, 4'b0100);
        end
        drive(1'b0, 4'h0, 4'h0, 3'd0, 2'd2, 4'b0100);
        checks++;
        if (stat_cnt !== 32'h00FF_0000 || mCnt[2] !== 8'd255) begin
            failures++;
            $display("[TB] FAIL stat_saturate: got %h required 00ff0000", stat_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_truth_table();
        test_backpressure();
        test_independence();
        test_invalid_sel();
        test_random();
`ifdef DEMUX_STAT_EN
        test_stat_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
